contador_tiempo: RTL

CONTADOR_TIEMPO -- requirements
Module: contador_tiempo

---
 rtl/contador_tiempo_pkg.sv | 41 ++++
 rtl/contador_tiempo_antirrebote.sv | 65 ++++++
 rtl/contador_tiempo.sv | 101 ++++++++++
 3 files changed

// File: rtl/contador_tiempo_pkg.sv
// Shared constants and BCD helpers for the clock project.
package contador_tiempo_pkg;

    localparam int CLK_HZ_DEFAULT       = 100000000;
    localparam int DEBOUNCE_CYC_DEFAULT = 1000000;

    // Field limits for seconds/minutes and for hours.
    localparam int MS_LIMIT = 59;
    localparam int HR_LIMIT = 23;

    // Two-digit BCD field.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    // True when the field sits at its last legal value and the next step wraps.
    function automatic logic bcd_at_limit(input bcd2_t cur, input int limit);
        logic [3:0] lim_t;
        logic [3:0] lim_u;
        lim_t = 4'(limit / 10);
        lim_u = 4'(limit % 10);
        return (cur.tens == lim_t) && (cur.units == lim_u);
    endfunction

    // Next value of a BCD field: units roll 9->0 into tens, limit rolls to 00.
    function automatic bcd2_t bcd_next(input bcd2_t cur, input int limit);
        bcd2_t res;
        res = cur;
        if (bcd_at_limit(cur, limit)) begin
            res = '0;
        end else if (cur.units == 4'd9) begin
            res.tens  = cur.tens + 4'd1;
            res.units = 4'd0;
        end else begin
            res.units = cur.units + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/contador_tiempo_antirrebote.sv
// Button conditioning: 2-flop synchroniser, stability debouncer and a
// one-cycle press pulse on the rising edge of the debounced level.
module antirrebote
    import contador_tiempo_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          prime1;
    logic          prime2;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchronise the raw button; prime flags mark when sync2 holds a real sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prime1 <= 1'b0;
            prime2 <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            prime1 <= 1'b1;
            prime2 <= prime1;
        end
    end

    // Accept a new level after DEBOUNCE_CYC identical samples; presses only
    // count once the button has been seen genuinely released since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (prime2 && !sync2 && !level) begin
                armed <= 1'b1;
            end
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2 & armed;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/contador_tiempo.sv
// HH:MM:SS BCD clock with 1 Hz prescaler, blinking colon and two
// debounced set buttons (minutes, hours).
module contador_tiempo
    import contador_tiempo_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_min,
    input  logic        btn_hr,
    output logic [15:0] digits,
    output logic        colon,
    output logic        tick_1hz
);

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    bcd2_t         secs;
    bcd2_t         mins;
    bcd2_t         hrs;
    bcd2_t         secs_next;
    bcd2_t         mins_next;
    bcd2_t         hrs_next;
    logic          press_min;
    logic          press_hr;

    antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_min (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_min),
        .press (press_min)
    );

    antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_hr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_hr),
        .press (press_hr)
    );

    assign tick_1hz = (presc == PRESC_LAST);

    // Next-state time: a minute press overrides the tick and its carries;
    // an hour press replaces any carry into hours so hours move by one.
    always_comb begin
        presc_next = tick_1hz ? '0 : presc + PW'(1);
        secs_next  = secs;
        mins_next  = mins;
        hrs_next   = hrs;
        if (press_min) begin
            presc_next = '0;
            secs_next  = '0;
            mins_next  = bcd_next(mins, MS_LIMIT);
        end else if (tick_1hz) begin
            secs_next = bcd_next(secs, MS_LIMIT);
            if (bcd_at_limit(secs, MS_LIMIT)) begin
                mins_next = bcd_next(mins, MS_LIMIT);
                if (bcd_at_limit(mins, MS_LIMIT)) begin
                    hrs_next = bcd_next(hrs, HR_LIMIT);
                end
            end
        end
        if (press_hr) begin
            hrs_next = bcd_next(hrs, HR_LIMIT);
        end
    end

    // Count state: prescaler and the three BCD fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            secs  <= '0;
            mins  <= '0;
            hrs   <= '0;
        end else begin
            presc <= presc_next;
            secs  <= secs_next;
            mins  <= mins_next;
            hrs   <= hrs_next;
        end
    end

    // Display outputs: digits trail the count state by one clock; colon
    // tracks the prescaler value it will hold this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits <= 16'h0000;
            colon  <= 1'b0;
        end else begin
            digits <= {hrs, mins};
            colon  <= (presc_next < PRESC_HALF);
        end
    end

endmodule
